// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory fetch/loader block.
package imem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of byte-offset bits below the word index for a given word width.
   function automatic int offs_bits(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W single-write / single-read RAM with a registered read port.
module imem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DATA_W-1:0] rdata_r;

   // Write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Read port; the register holds its value when no read is issued.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata_r <= mem_r[raddr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/imem_fetch_loader.sv
// Instruction memory with a single-cycle fetch port and a burst loader that
// fills it word by word; fetches are blocked while a burst is in progress.
module imem_fetch_loader
   import imem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     fetch_req,
   input  logic [ADDR_W-1:0]        fetch_addr,
   output logic                     fetch_ready,
   output logic                     fetch_valid,
   output logic [DATA_W-1:0]        fetch_data,
   output logic                     fetch_fault,
   input  logic                     load_start,
   input  logic [ADDR_W-1:0]        load_base,
   input  logic [$clog2(DEPTH):0]   load_count,
   input  logic                     load_valid,
   input  logic [DATA_W-1:0]        load_data,
   output logic                     load_ready,
   output logic                     load_done,
   output logic                     load_err
);

   localparam int OFFS = offs_bits(DATA_W);
   localparam int IDXW = $clog2(DEPTH);
   localparam int CW   = IDXW + 1;

   state_t            state_r, state_nxt_s;
   logic [IDXW-1:0]   ptr_r, ptr_nxt_s;
   logic [CW-1:0]     rem_r, rem_nxt_s;
   logic              we_s;
   logic              err_s;
   logic              fetch_acc_s;
   logic              fetch_bad_s;
   logic              fetch_valid_r;
   logic              fetch_fault_r;
   logic              fetch_zero_r;
   logic              load_done_r;
   logic              load_err_r;
   logic [DATA_W-1:0] ram_q_s;
   logic              unused_base_s;

   assign unused_base_s = ^load_base[ADDR_W-1:OFFS+IDXW];

   assign fetch_ready = (state_r == ST_IDLE) || (state_r == ST_DONE);
   assign load_ready  = (state_r == ST_LOAD);
   assign fetch_acc_s = fetch_req && fetch_ready;
   assign fetch_bad_s = (|fetch_addr[OFFS-1:0]) || ((fetch_addr >> OFFS) >= ADDR_W'(DEPTH));

   // Loader sequencing: pointer/count capture, beat writes and burst termination.
   always_comb begin
      state_nxt_s = state_r;
      ptr_nxt_s   = ptr_r;
      rem_nxt_s   = rem_r;
      we_s        = 1'b0;
      err_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (load_start) begin
               if (|load_base[OFFS-1:0]) begin
                  err_s = 1'b1;
               end else begin
                  ptr_nxt_s   = load_base[OFFS +: IDXW];
                  rem_nxt_s   = load_count;
                  state_nxt_s = (load_count == {CW{1'b0}}) ? ST_DONE : ST_LOAD;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (load_valid) begin
               we_s        = 1'b1;
               ptr_nxt_s   = ptr_r + IDXW'(1);
               rem_nxt_s   = rem_r - CW'(1);
               state_nxt_s = (rem_r == CW'(1)) ? ST_DONE : ST_LOAD;
            end else begin
               state_nxt_s = ST_LOAD;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Loader state, pointer, remaining count and status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         ptr_r       <= {IDXW{1'b0}};
         rem_r       <= {CW{1'b0}};
         load_done_r <= 1'b0;
         load_err_r  <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         ptr_r       <= ptr_nxt_s;
         rem_r       <= rem_nxt_s;
         load_done_r <= (state_nxt_s == ST_DONE);
         load_err_r  <= err_s;
      end
   end

   // Fetch result flags; fetch_zero_r masks RAM output after reset and on faults.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_valid_r <= 1'b0;
         fetch_fault_r <= 1'b0;
         fetch_zero_r  <= 1'b1;
      end else begin
         fetch_valid_r <= fetch_acc_s;
         if (fetch_acc_s) begin
            fetch_fault_r <= fetch_bad_s;
            fetch_zero_r  <= fetch_bad_s;
         end
      end
   end

   imem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (IDXW)
   ) u_array (
      .clk   (clk),
      .we    (we_s),
      .waddr (ptr_r),
      .wdata (load_data),
      .re    (fetch_acc_s && !fetch_bad_s),
      .raddr (fetch_addr[OFFS +: IDXW]),
      .rdata (ram_q_s)
   );

   assign fetch_valid = fetch_valid_r;
   assign fetch_fault = fetch_fault_r;
   assign fetch_data  = fetch_zero_r ? {DATA_W{1'b0}} : ram_q_s;
   assign load_done   = load_done_r;
   assign load_err    = load_err_r;

endmodule

// File: tb/tb_imem_fetch_loader.sv
// Self-checking bench: fetch vector table plus scoreboard, and hand-written loader sequences.
module tb_imem_fetch_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ready;
   logic        fetch_valid;
   logic [31:0] fetch_data;
   logic        fetch_fault;
   logic        load_start;
   logic [31:0] load_base;
   logic [8:0]  load_count;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_ready;
   logic        load_done;
   logic        load_err;

   typedef struct {
      logic [31:0] addr;
      logic        fault;
      logic [31:0] data;
   } fvec_t;

   typedef struct {
      logic        fault;
      logic [31:0] data;
   } exp_t;

   exp_t        sb_q[$];
   fvec_t       vecs[14];
   logic [31:0] burst_d[8];
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;

   imem_fetch_loader #(.DATA_W(32), .DEPTH(256), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_fault(fetch_fault),
      .load_start(load_start), .load_base(load_base), .load_count(load_count),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every fetch_valid must match the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (load_done === 1'b1) done_cnt++;
      if (fetch_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_fetch_valid", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            chk("fetch_fault", {63'd0, fetch_fault}, {63'd0, e.fault});
            chk("fetch_data", {32'd0, fetch_data}, {32'd0, e.data});
         end
      end
   end

   task automatic push_exp(input logic f, input logic [31:0] d);
      exp_t e;
      e.fault = f;
      e.data  = d;
      sb_q.push_back(e);
   endtask

   // Single fetch issued from IDLE.
   task automatic do_fetch(input logic [31:0] a, input logic f, input logic [31:0] d);
      fetch_req  = 1'b1;
      fetch_addr = a;
      chk("fetch_ready_idle", {63'd0, fetch_ready}, 64'd1);
      push_exp(f, d);
      tick();
      fetch_req = 1'b0;
   endtask

   // Burst of cnt words from burst_d, with a one-cycle stall before odd beats.
   task automatic load_burst(input logic [31:0] base, input int cnt);
      int d0;
      d0 = done_cnt;
      load_start = 1'b1;
      load_base  = base;
      load_count = 9'(cnt);
      tick();
      load_start = 1'b0;
      chk("load_ready_in_load", {63'd0, load_ready}, 64'd1);
      for (int i = 0; i < cnt; i++) begin
         if (i % 2 == 1) begin
            load_valid = 1'b0;
            tick();
            chk("load_done_during_gap", {63'd0, load_done}, 64'd0);
         end
         load_valid = 1'b1;
         load_data  = burst_d[i];
         tick();
      end
      load_valid = 1'b0;
      chk("load_done_pulse", {63'd0, load_done}, 64'd1);
      chk("fetch_ready_done", {63'd0, fetch_ready}, 64'd1);
      tick();
      chk("load_done_clear", {63'd0, load_done}, 64'd0);
      chk("load_done_count", 64'(done_cnt - d0), 64'd1);
   endtask

   initial begin
      rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = 32'd0; load_start = 1'b0;
      load_base = 32'd0; load_count = 9'd0; load_valid = 1'b0; load_data = 32'd0;

      vecs[0]  = '{32'h0000_0010, 1'b0, 32'hA0A0_0001};
      vecs[1]  = '{32'h0000_0014, 1'b0, 32'hB0B0_0002};
      vecs[2]  = '{32'h0000_0018, 1'b0, 32'hC0C0_0003};
      vecs[3]  = '{32'h0000_0002, 1'b1, 32'h0000_0000};
      vecs[4]  = '{32'h0000_0400, 1'b1, 32'h0000_0000};
      vecs[5]  = '{32'h0000_03F8, 1'b0, 32'hD000_0000};
      vecs[6]  = '{32'h0000_03FC, 1'b0, 32'hD000_0001};
      vecs[7]  = '{32'h0000_0000, 1'b0, 32'hD000_0002};
      vecs[8]  = '{32'h0000_0004, 1'b0, 32'hD000_0003};
      vecs[9]  = '{32'h0000_03FE, 1'b1, 32'h0000_0000};
      vecs[10] = '{32'hFFFF_FFFC, 1'b1, 32'h0000_0000};
      vecs[11] = '{32'h0000_0010, 1'b0, 32'hA0A0_0001};
      vecs[12] = '{32'h0000_0001, 1'b1, 32'h0000_0000};
      vecs[13] = '{32'h0000_0018, 1'b0, 32'hC0C0_0003};

      // Reset state
      tick(); tick();
      chk("rst_fetch_valid", {63'd0, fetch_valid}, 64'd0);
      chk("rst_fetch_fault", {63'd0, fetch_fault}, 64'd0);
      chk("rst_fetch_data", {32'd0, fetch_data}, 64'd0);
      chk("rst_load_done", {63'd0, load_done}, 64'd0);
      chk("rst_load_err", {63'd0, load_err}, 64'd0);
      chk("rst_fetch_ready", {63'd0, fetch_ready}, 64'd1);
      chk("rst_load_ready", {63'd0, load_ready}, 64'd0);
      rst_n = 1'b1;
      tick();

      // Burst A,B,C at 0x10, then a wrapping burst at 0x3F8
      burst_d[0] = 32'hA0A0_0001; burst_d[1] = 32'hB0B0_0002; burst_d[2] = 32'hC0C0_0003;
      load_burst(32'h0000_0010, 3);
      for (int i = 0; i < 4; i++) burst_d[i] = 32'hD000_0000 + 32'(i);
      load_burst(32'h0000_03F8, 4);

      // Back-to-back table fetches
      for (int i = 0; i < 14; i++) begin
         fetch_req  = 1'b1;
         fetch_addr = vecs[i].addr;
         chk("fetch_ready_table", {63'd0, fetch_ready}, 64'd1);
         push_exp(vecs[i].fault, vecs[i].data);
         tick();
      end
      fetch_req = 1'b0;
      tick(); tick();
      chk("hold_valid_low", {63'd0, fetch_valid}, 64'd0);
      chk("hold_data", {32'd0, fetch_data}, {32'd0, 32'hC0C0_0003});

      // Misaligned load_start
      load_start = 1'b1; load_base = 32'h0000_0006; load_count = 9'd2;
      tick();
      load_start = 1'b0;
      chk("load_err_pulse", {63'd0, load_err}, 64'd1);
      chk("err_stays_idle", {63'd0, load_ready}, 64'd0);
      chk("err_fetch_ready", {63'd0, fetch_ready}, 64'd1);
      tick();
      chk("load_err_clear", {63'd0, load_err}, 64'd0);

      // Zero-length burst goes straight to DONE and writes nothing
      load_start = 1'b1; load_base = 32'h0000_0010; load_count = 9'd0;
      tick();
      load_start = 1'b0;
      chk("zero_load_done", {63'd0, load_done}, 64'd1);
      chk("zero_load_ready", {63'd0, load_ready}, 64'd0);
      tick();
      chk("zero_done_clear", {63'd0, load_done}, 64'd0);
      do_fetch(32'h0000_0010, 1'b0, 32'hA0A0_0001);

      // Preload 0x40, then simultaneous fetch+load_start and fetch held through LOAD
      burst_d[0] = 32'hE000_0000;
      load_burst(32'h0000_0040, 1);
      load_start = 1'b1; load_base = 32'h0000_0040; load_count = 9'd2;
      fetch_req = 1'b1; fetch_addr = 32'h0000_0040;
      chk("simul_fetch_ready", {63'd0, fetch_ready}, 64'd1);
      push_exp(1'b0, 32'hE000_0000);
      tick();
      load_start = 1'b0;
      chk("load_fetch_ready_low", {63'd0, fetch_ready}, 64'd0);
      load_valid = 1'b0;
      tick();
      chk("gap_fetch_ready_low", {63'd0, fetch_ready}, 64'd0);
      load_valid = 1'b1; load_data = 32'hF000_0000;
      tick();
      chk("beat_fetch_ready_low", {63'd0, fetch_ready}, 64'd0);
      load_data = 32'hF000_0001;
      tick();
      load_valid = 1'b0;
      chk("done_fetch_ready", {63'd0, fetch_ready}, 64'd1);
      chk("done_pulse_fetch", {63'd0, load_done}, 64'd1);
      push_exp(1'b0, 32'hF000_0000);
      tick();
      fetch_req = 1'b0;
      tick();

      // Reset after 2 of 5 beats
      for (int i = 0; i < 5; i++) burst_d[i] = 32'h6000_0000 + 32'(i);
      begin
         int d0;
         d0 = done_cnt;
         load_start = 1'b1; load_base = 32'h0000_0080; load_count = 9'd5;
         tick();
         load_start = 1'b0;
         load_valid = 1'b1; load_data = burst_d[0];
         tick();
         load_data = burst_d[1];
         tick();
         load_valid = 1'b0;
         chk("pre_rst_load_ready", {63'd0, load_ready}, 64'd1);
         rst_n = 1'b0;
         #1;
         chk("async_rst_load_ready", {63'd0, load_ready}, 64'd0);
         chk("async_rst_fetch_ready", {63'd0, fetch_ready}, 64'd1);
         tick(); tick();
         rst_n = 1'b1;
         tick(); tick();
         chk("no_done_after_rst", 64'(done_cnt - d0), 64'd0);
      end
      do_fetch(32'h0000_0080, 1'b0, 32'h6000_0000);
      do_fetch(32'h0000_0084, 1'b0, 32'h6000_0001);
      tick(); tick();
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_fetch_loader.md
IMEM_FETCH_LOADER -- requirements
Module: imem_fetch_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 256, number of words; power of two, minimum 4.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-007 SHALL have port fetch_req, input, 1 bit, fetch request, sampled when fetch_ready=1.
REQ-008 SHALL have port fetch_addr, input, ADDR_W bits, byte address (PC) of the fetch.
REQ-009 SHALL have port fetch_ready, output, 1 bit, high when a fetch can be accepted.
REQ-010 SHALL have port fetch_valid, output, 1 bit, result-valid strobe.
REQ-011 SHALL have port fetch_data, output, DATA_W bits, instruction read.
REQ-012 SHALL have port fetch_fault, output, 1 bit, fetch misaligned or out of range; qualified by fetch_valid.
REQ-013 SHALL have port load_start, input, 1 bit, starts a burst load; sampled in IDLE only.
REQ-014 SHALL have port load_base, input, ADDR_W bits, byte address of the first loaded word.
REQ-015 SHALL have port load_count, input, $clog2(DEPTH)+1 bits, number of words in the burst.
REQ-016 SHALL have ports load_valid (input, 1), load_data (input, DATA_W), load_ready (output, 1), the load beat handshake.
REQ-017 SHALL have port load_done, output, 1 bit, one-cycle pulse at burst end.
REQ-018 SHALL have port load_err, output, 1 bit, one-cycle pulse when load_start is rejected.

Function
REQ-019 SHALL define OFFS=$clog2(DATA_W/8); word index = addr[OFFS+$clog2(DEPTH)-1:OFFS].
REQ-020 SHALL implement FSM states IDLE, LOAD, DONE.
- IDLE -> LOAD on load_start with aligned base.
- LOAD -> DONE on the last accepted beat.
- DONE -> IDLE unconditionally after one cycle.
REQ-021 SHALL drive fetch_ready=1 only in IDLE and DONE, and load_ready=1 only in LOAD.
REQ-022 SHALL treat a fetch as accepted when fetch_req=1 and fetch_ready=1, and SHALL register its result so fetch_valid=1 exactly one cycle after acceptance (latency 1, back-to-back every cycle).
REQ-023 SHALL set fetch_fault=1 and fetch_data=0 when addr[OFFS-1:0]!=0 or addr>>OFFS >= DEPTH.
REQ-024 SHALL otherwise return mem[index] with fetch_fault=0.
REQ-025 SHALL hold fetch_data at its last value and fetch_valid=0 in any cycle with no accepted fetch.
REQ-026 SHALL, on load_start in IDLE, latch the word pointer from load_base and the remaining count from load_count.
REQ-027 SHALL, on load_start with misaligned load_base, pulse load_err for one cycle and stay in IDLE.
REQ-028 SHALL, on load_start with load_count=0, go directly to DONE and write nothing.
REQ-029 SHALL, on each beat (load_valid and load_ready), write load_data to mem[ptr], increment ptr modulo DEPTH (wrap-around), and decrement remaining.
REQ-030 SHALL write nothing on cycles with load_valid=0; stalls of any length are legal.
REQ-031 SHALL assert load_done=1 exactly in the DONE state.
REQ-032 SHALL accept both a fetch and load_start when they are asserted in the same IDLE cycle; the fetch sees pre-load contents.
REQ-033 SHALL ignore load_start in LOAD and DONE.
REQ-034 SHALL let a fetch accepted in DONE observe all words written by the completed burst.

Reset
REQ-035 SHALL, on rst_n=0, immediately force state=IDLE, fetch_valid=0, fetch_fault=0, fetch_data=0, load_done=0, load_err=0, ptr=0, remaining=0.
REQ-036 SHALL NOT reset memory contents; reset mid-LOAD aborts the burst with no load_done, and words already written persist.

Structure
REQ-037 SHALL place the state enum and OFFS derivation helper in shared package imem_pkg.
REQ-038 SHALL instantiate one sub-module, imem_array: a 1-write/1-read synchronous-read RAM of DEPTH x DATA_W.

Verification
REQ-039 Bench SHALL cover: reset, then a burst with base=0x10, count=3, data A,B,C and load_valid gaps -> load_done pulses once after the third beat; fetches of 0x10/0x14/0x18 return A/B/C one cycle after request.
REQ-040 Bench SHALL cover: fetch 0x2 -> fetch_valid=1, fetch_fault=1, fetch_data=0; fetch 0x400 with DEPTH=256 -> fetch_fault=1.
REQ-041 Bench SHALL cover: burst with base=0x3F8, count=4 -> words land at indices 254, 255, 0, 1.
REQ-042 Bench SHALL cover: load_start with base=0x6 -> load_err pulse, state stays IDLE; load_count=0 -> load_done on the next cycle with no writes.
REQ-043 Bench SHALL cover: fetch_req held high during LOAD -> fetch_ready=0 and no fetch_valid until DONE; a simultaneous fetch and load_start in IDLE returns old data.
REQ-044 Bench SHALL cover: rst_n low after 2 of 5 beats -> immediate IDLE, no load_done, first 2 words are readable after reset.
